array_sort_check_param: RTL and testbench
=========================================

# array_sort_check_param

Parametrised, self-contained array sortedness checker: controller plus datapath in one block. It streams an array from a synchronous-read memory port and compares each adjacent pair. It supports ascending/descending order, strict/non-strict order, and signed/unsigned compare. It reports sorted/unsorted and the index of the first inversion. It sits between a host-side `go`/`done` handshake and a single-port array RAM.

## Interface
- `DATA_WIDTH`, 32: element width in bits.
- `ADDR_WIDTH`, 8: RAM address width; maximum array length is 2^ADDR_WIDTH.
- `clock` in 1: the only clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `go` in 1: start request, sampled on the rising edge.
- `length` in ADDR_WIDTH+1: element count; values above 2^ADDR_WIDTH are clamped to 2^ADDR_WIDTH.
- `descending` in 1: 0 checks for ascending order, 1 for descending order.
- `strict` in 1: 1 treats equal neighbours as an inversion.
- `signed_cmp` in 1: 1 compares elements as two's complement.
- `rd_en` out 1: RAM read enable.
- `rd_addr` out ADDR_WIDTH: RAM read address.
- `rd_data` in DATA_WIDTH: RAM data; valid one cycle after the matching `rd_en`/`rd_addr`.
- `busy` out 1: high while a check is in progress.
- `done` out 1: result valid; held until the next accepted `go`.
- `sorted` out 1: result flag; meaningful only while `done`=1.
- `inv_index` out ADDR_WIDTH: index i of the first inversion pair (i-1, i); 0 when sorted.
- `inv_count` out ADDR_WIDTH+1: total number of inversion pairs; exists only with the macro described under Configuration.

## Operation
- FSM states: IDLE, PRIME, LOAD, SCAN, DONE.
- Reset (asynchronous, takes effect immediately, including mid-check) forces:
  - state IDLE;
  - `busy`, `done`, `sorted`, `rd_en` = 0;
  - `rd_addr`, `inv_index`, `inv_count` = 0.
- Starting a check:
  - `go` is accepted in IDLE or DONE and ignored in PRIME, LOAD and SCAN.
  - On acceptance, `length` (clamped), `descending`, `strict` and `signed_cmp` are latched; later changes to these inputs do not affect the check in flight.
  - `done`, `sorted`, `inv_index` and `inv_count` clear on the accepting edge.
- Short arrays: if the latched length is 0 or 1, the next state is DONE with `sorted`=1, `inv_index`=0, and no reads are issued.
- PRIME: `rd_en`=1, `rd_addr`=0.
- LOAD: captures `rd_data` (element 0) into the previous-element register; `rd_en`=1, `rd_addr`=1.
- SCAN, current index i:
  - compares prev against cur = `rd_data`, then prev <= cur;
  - issues the read for i+1 only when i+1 < length;
  - leaves for DONE after comparing i = length-1.
- Inversion rule:
  - ascending, non-strict: prev > cur;
  - ascending, strict: prev >= cur;
  - descending, non-strict: prev < cur;
  - descending, strict: prev <= cur.
  - `signed_cmp` selects the signed or unsigned magnitude compare.
- `inv_index` records only the first inversion; later inversions never overwrite it.
- DONE: `busy`=0, `done`=1, `sorted` = no inversion found; the state holds until `go` or reset.

## Timing
- `busy` rises on the edge that accepts `go` and falls on the edge that enters DONE.
- Latency, counted in edges after the accepting edge:
  - length N ≥ 2, full scan: `done` rises N+1 edges later (PRIME, LOAD, then N-1 SCAN cycles).
  - length 0 or 1: `done` rises 1 edge later.
- `rd_addr` never reaches a value ≥ the latched length; `rd_en`=0 in IDLE and DONE and during the final SCAN cycle.
- `go` held high across DONE restarts the check on every entry to DONE; `done` is high for exactly one cycle between checks.

## Configuration
- Macro: `ARRAY_SORT_CHECK_COUNT_EN`.
- Defined:
  - the `inv_count` port exists;
  - SCAN always runs to the last element;
  - `inv_count` increments once per inversion and saturates at 2^ADDR_WIDTH;
  - latency is always N+1.
- Undefined:
  - there is no `inv_count` port and no counter;
  - SCAN exits to DONE on the edge after the first inversion is detected;
  - for an inversion at index k, `done` rises k+2 edges after the accepting edge;
  - reads stop as soon as SCAN exits.

## Test plan
- Ascending check, non-strict, unsigned, N=4, array {1,2,2,5} → `done` after 5 edges, `sorted`=1, `inv_index`=0, `inv_count`=0; exactly 4 reads, at addresses 0..3.
- Same array with `strict`=1 → `sorted`=0, `inv_index`=2, `inv_count`=1 (with macro); without macro, `done` 4 edges after the accepting edge.
- `descending`=1, `signed_cmp`=1, array {3, 0, -1 (all ones), -8} → `sorted`=1; the same array with `signed_cmp`=0 → `sorted`=0, `inv_index`=2.
- N=0 and N=1 → `done` 1 edge after `go`, `sorted`=1, `rd_en` never asserted.
- Array {5,1,4,0}, ascending, non-strict:
  - with macro: `inv_count`=2, `inv_index`=1;
  - `go` pulsed while `busy` is ignored;
  - `reset` low mid-SCAN clears all outputs immediately and returns to IDLE.
- N=2^ADDR_WIDTH (and `length` above it, clamped) on a fully ascending array → `sorted`=1; the last read address is 2^ADDR_WIDTH-1 and there is no address wrap.

Source files
------------

// File: rtl/array_sort_check_param.sv
`default_nettype none
// ============================================================================
// Module  : array_sort_check_param
// Purpose : Streams an array from a synchronous-read RAM port and checks that
//           every adjacent pair (i-1, i) obeys the requested order.
//           Order is ascending or descending, strict or non-strict, and the
//           elements are compared signed or unsigned. Reports sorted/unsorted
//           and the index of the first inversion.
// Optional: define ARRAY_SORT_CHECK_COUNT_EN to add the inv_count_o port. The
//           scan then always runs to the last element and counts every
//           inversion (saturating at 2^ADDR_WIDTH). Without it the scan stops
//           right after the first inversion.
// Ports   : clock_i       - clock, rising edge active
//           reset_ni      - asynchronous active-low reset
//           go_i          - start request (accepted in IDLE or DONE)
//           length_i      - element count, clamped to 2^ADDR_WIDTH
//           descending_i  - 0 ascending, 1 descending
//           strict_i      - 1 treats equal neighbours as an inversion
//           signed_cmp_i  - 1 compares as two's complement
//           rd_en_o/rd_addr_o/rd_data_i - RAM port, data one cycle after read
//           busy_o        - check in progress
//           done_o        - result valid, held until next accepted go
//           sorted_o      - no inversion found (valid with done_o)
//           inv_index_o   - index i of first inversion pair (i-1, i)
//           inv_count_o   - number of inversion pairs (optional)
// Revision: 1.0 - initial release
// ============================================================================
module array_sort_check_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  go_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    input  logic                  descending_i,
    input  logic                  strict_i,
    input  logic                  signed_cmp_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sorted_o,
`ifdef ARRAY_SORT_CHECK_COUNT_EN
    output logic [ADDR_WIDTH:0]   inv_count_o,
`endif
    output logic [ADDR_WIDTH-1:0] inv_index_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRIME = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] TWO     = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q;
    logic                  desc_q, strict_q, signed_q;
    logic [ADDR_WIDTH:0]   idx_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic                  found_q;
    logic [ADDR_WIDTH-1:0] inv_index_q;

    logic                  w_accept;
    logic [ADDR_WIDTH:0]   w_len_clamp;
    logic                  w_short;
    logic [ADDR_WIDTH:0]   w_next_idx;
    logic                  w_last;
    logic                  w_gt, w_eq, w_lt, w_inv;

    assign w_accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) && go_i;
    assign w_len_clamp = (length_i > MAX_LEN) ? MAX_LEN : length_i;
    assign w_short     = (len_q < TWO);
    // idx_q is one bit wider than an address so i+1 == 2^ADDR_WIDTH is
    // representable and the final-element test never wraps.
    assign w_next_idx  = idx_q + ONE;
    assign w_last      = (w_next_idx >= len_q);

    // Compare prev (element i-1) against cur (rd_data_i, element i).
    assign w_gt = signed_q ? ($signed(prev_q) > $signed(rd_data_i))
                           : (prev_q > rd_data_i);
    assign w_eq = (prev_q == rd_data_i);
    assign w_lt = !w_gt && !w_eq;
    assign w_inv = desc_q ? (strict_q ? (w_lt || w_eq) : w_lt)
                          : (strict_q ? (w_gt || w_eq) : w_gt);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept) state_d = S_PRIME;
            // Short arrays pass through PRIME without reading, so done
            // rises exactly one edge after acceptance.
            S_PRIME: state_d = w_short ? S_DONE : S_LOAD;
            S_LOAD:  state_d = S_SCAN;
            S_SCAN: begin
`ifdef ARRAY_SORT_CHECK_COUNT_EN
                if (w_last) state_d = S_DONE;
`else
                if (w_last || w_inv) state_d = S_DONE;
`endif
            end
            S_DONE:  if (w_accept) state_d = S_PRIME;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        rd_en_o   = 1'b0;
        rd_addr_o = '0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        sorted_o  = 1'b0;
        case (state_q)
            S_PRIME: begin
                busy_o    = 1'b1;
                rd_en_o   = !w_short;
            end
            S_LOAD: begin
                busy_o    = 1'b1;
                rd_en_o   = 1'b1;
                rd_addr_o = ADDR_WIDTH'(1);
            end
            S_SCAN: begin
                busy_o    = 1'b1;
                rd_en_o   = !w_last;
                // Drive the address only with a real read so it never
                // reaches or wraps past the latched length.
                rd_addr_o = w_last ? '0 : w_next_idx[ADDR_WIDTH-1:0];
            end
            S_DONE: begin
                done_o    = 1'b1;
                sorted_o  = !found_q;
            end
            default: ;
        endcase
    end

    assign inv_index_o = inv_index_q;

    // ------------------------------------------------------------------
    // Datapath: latched configuration, element pipeline, result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            len_q       <= '0;
            desc_q      <= 1'b0;
            strict_q    <= 1'b0;
            signed_q    <= 1'b0;
            idx_q       <= '0;
            prev_q      <= '0;
            found_q     <= 1'b0;
            inv_index_q <= '0;
        end else if (w_accept) begin
            len_q       <= w_len_clamp;
            desc_q      <= descending_i;
            strict_q    <= strict_i;
            signed_q    <= signed_cmp_i;
            idx_q       <= '0;
            found_q     <= 1'b0;
            inv_index_q <= '0;
        end else if (state_q == S_LOAD) begin
            prev_q <= rd_data_i;
            idx_q  <= ONE;
        end else if (state_q == S_SCAN) begin
            prev_q <= rd_data_i;
            idx_q  <= w_next_idx;
            if (w_inv && !found_q) begin
                found_q     <= 1'b1;
                inv_index_q <= idx_q[ADDR_WIDTH-1:0];
            end
        end
    end

`ifdef ARRAY_SORT_CHECK_COUNT_EN
    logic [ADDR_WIDTH:0] inv_count_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            inv_count_q <= '0;
        end else if (w_accept) begin
            inv_count_q <= '0;
        end else if ((state_q == S_SCAN) && w_inv && (inv_count_q != MAX_LEN)) begin
            inv_count_q <= inv_count_q + ONE;
        end
    end

    assign inv_count_o = inv_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_array_sort_check_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_array_sort_check_param
// Purpose : Self-checking bench for array_sort_check_param (DATA_WIDTH=8,
//           ADDR_WIDTH=4). Table vectors, hand sequences and random arrays
//           checked against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_array_sort_check_param;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int MAX = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic [AW:0]   length;
    logic          descending, strict, signed_cmp;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy, done, sorted;
    logic [AW-1:0] inv_index;
`ifdef ARRAY_SORT_CHECK_COUNT_EN
    logic [AW:0]   inv_count;
`endif

    always #5 clk = ~clk;

    array_sort_check_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock_i      (clk),
        .reset_ni     (rst_n),
        .go_i         (go),
        .length_i     (length),
        .descending_i (descending),
        .strict_i     (strict),
        .signed_cmp_i (signed_cmp),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .busy_o       (busy),
        .done_o       (done),
        .sorted_o     (sorted),
`ifdef ARRAY_SORT_CHECK_COUNT_EN
        .inv_count_o  (inv_count),
`endif
        .inv_index_o  (inv_index)
    );

    // Synchronous-read RAM plus a read monitor
    logic [DW-1:0] mem [MAX];
    int tb_len     = 0;
    int rd_total   = 0;
    int err_total  = 0;
    int last_addr  = -1;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data   <= mem[rd_addr];
            rd_total  = rd_total + 1;
            last_addr = int'(rd_addr);
            if (int'(rd_addr) >= tb_len) err_total = err_total + 1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: straight walk over the array with integer compares
    // ------------------------------------------------------------------
    function automatic int sval(input logic [DW-1:0] x, input bit sgn);
        return sgn ? int'($signed(x)) : int'(x);
    endfunction

    function automatic void model(input int n, input bit d, s, g,
                                  output bit srt, output int idx,
                                  output int cnt, output int lat);
        int a, b;
        bit inv;
        srt = 1'b1; idx = 0; cnt = 0;
        for (int i = 1; i < n; i++) begin
            a = sval(mem[i-1], g);
            b = sval(mem[i], g);
            inv = d ? (s ? (a <= b) : (a < b)) : (s ? (a >= b) : (a > b));
            if (inv) begin
                if (srt) idx = i;
                srt = 1'b0;
                cnt++;
            end
        end
        if (n <= 1) lat = 1;
`ifdef ARRAY_SORT_CHECK_COUNT_EN
        else lat = n + 1;
`else
        else lat = srt ? n + 1 : idx + 2;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Run one check; poke pulses go while busy (must be ignored)
    // ------------------------------------------------------------------
    task automatic do_test(input string nm, input int len_in, input bit d, s, g,
                           input bit poke, input bit use_tab,
                           input bit t_srt, input int t_idx, input int t_cnt);
        int r0, e0, lat, n, m_idx, m_cnt, m_lat, cnt;
        bit m_srt;
        n = (len_in > MAX) ? MAX : len_in;
        model(n, d, s, g, m_srt, m_idx, m_cnt, m_lat);
        if (use_tab) begin
            m_srt = t_srt; m_idx = t_idx; m_cnt = t_cnt;
        end
        @(negedge clk);
        length = (AW+1)'(len_in);
        descending = d; strict = s; signed_cmp = g;
        go = 1'b1;
        tb_len = n;
        r0 = rd_total; e0 = err_total;
        @(posedge clk); #1;
        go = 1'b0;
        // configuration must already be latched
        length     = (AW+1)'($urandom_range(0, 31));
        descending = 1'($urandom_range(0, 1));
        strict     = 1'($urandom_range(0, 1));
        signed_cmp = 1'($urandom_range(0, 1));
        chk({nm, " busy_on_accept"}, busy, 1);
        chk({nm, " done_cleared"}, done, 0);
        lat = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk); #1;
            lat++;
            if (poke) begin
                go = (lat == 1);
                length = '0;
            end
        end
        go = 1'b0;
        chk({nm, " latency"}, lat, m_lat);
        chk({nm, " done"}, done, 1);
        chk({nm, " busy_off"}, busy, 0);
        chk({nm, " sorted"}, sorted, m_srt);
        chk({nm, " inv_index"}, inv_index, m_idx);
`ifdef ARRAY_SORT_CHECK_COUNT_EN
        cnt = int'(inv_count);
        chk({nm, " inv_count"}, cnt, m_cnt);
`else
        cnt = m_cnt;
`endif
        chk({nm, " rd_addr_in_range"}, err_total - e0, 0);
        if (n < 2) begin
            chk({nm, " no_reads"}, rd_total - r0, 0);
        end else begin
`ifdef ARRAY_SORT_CHECK_COUNT_EN
            chk({nm, " read_count"}, rd_total - r0, n);
            chk({nm, " last_addr"}, last_addr, n - 1);
`else
            if (m_srt) begin
                chk({nm, " read_count"}, rd_total - r0, n);
                chk({nm, " last_addr"}, last_addr, n - 1);
            end
`endif
        end
    endtask

    typedef struct {
        logic [DW-1:0] d0, d1, d2, d3;
        int n;
        bit desc, strict, sgn;
        bit e_srt;
        int e_idx, e_cnt;
    } vec_t;

    vec_t tab [8];
    int   run_len, max_run, pulses, wait_c, k;

    initial begin
        tab[0] = '{8'd1, 8'd2, 8'd2, 8'd5, 4, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
        tab[1] = '{8'd1, 8'd2, 8'd2, 8'd5, 4, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1};
        tab[2] = '{8'd3, 8'd0, 8'hFF, 8'hF8, 4, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0};
        tab[3] = '{8'd3, 8'd0, 8'hFF, 8'hF8, 4, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1};
        tab[4] = '{8'd5, 8'd1, 8'd4, 8'd0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2};
        tab[5] = '{8'd5, 8'd1, 8'd4, 8'd0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1};
        tab[6] = '{8'd9, 8'd1, 8'd4, 8'd0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
        tab[7] = '{8'd9, 8'd1, 8'd4, 8'd0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};

        for (int i = 0; i < MAX; i++) mem[i] = DW'($urandom);
        rst_n = 1'b0; go = 1'b0; length = '0;
        descending = 1'b0; strict = 1'b0; signed_cmp = 1'b0;
        #12;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sorted", sorted, 0);
        chk("reset rd_en", rd_en, 0);
        chk("reset rd_addr", rd_addr, 0);
        chk("reset inv_index", inv_index, 0);
        @(negedge clk); rst_n = 1'b1;

        // Table vectors
        for (int t = 0; t < 8; t++) begin
            mem[0] = tab[t].d0; mem[1] = tab[t].d1;
            mem[2] = tab[t].d2; mem[3] = tab[t].d3;
            do_test($sformatf("tab%0d", t), tab[t].n, tab[t].desc,
                    tab[t].strict, tab[t].sgn, 1'b0, 1'b1,
                    tab[t].e_srt, tab[t].e_idx, tab[t].e_cnt);
        end

        // go pulsed while busy is ignored
        mem[0] = 8'd5; mem[1] = 8'd1; mem[2] = 8'd4; mem[3] = 8'd0;
        do_test("go_while_busy", 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

        // Full-size array and clamped lengths
        for (int i = 0; i < MAX; i++) mem[i] = DW'(i * 3);
        do_test("max_len", MAX, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_test("clamp_17", MAX + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_test("clamp_31", 31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Random arrays: noisy, rising or falling runs
        for (int r = 0; r < 40; r++) begin
            k = $urandom_range(0, 2);
            mem[0] = DW'($urandom);
            for (int i = 1; i < MAX; i++) begin
                case (k)
                    0:       mem[i] = DW'($urandom_range(0, 3)) ^ (mem[i-1] & 8'hF0);
                    1:       mem[i] = mem[i-1] + DW'($urandom_range(0, 9));
                    default: mem[i] = mem[i-1] - DW'($urandom_range(0, 9));
                endcase
            end
            do_test($sformatf("rnd%0d", r), $urandom_range(0, 19),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 0, 0);
        end

        // go held high across DONE: done pulses for exactly one cycle
        mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3;
        @(negedge clk);
        length = 5'd3; descending = 1'b0; strict = 1'b0; signed_cmp = 1'b0;
        tb_len = 3; go = 1'b1;
        run_len = 0; max_run = 0; pulses = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (done) begin
                run_len++;
                if (run_len == 1) pulses++;
            end else begin
                run_len = 0;
            end
            if (run_len > max_run) max_run = run_len;
        end
        chk("held_go max_done_run", max_run, 1);
        chk("held_go pulses", pulses, 3);
        go = 1'b0;
        wait_c = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk); #1; wait_c++;
        end
        chk("held_go final done", done, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done held", done, 1);
        chk("done held sorted", sorted, 1);

        // Asynchronous reset in the middle of SCAN
        for (int i = 0; i < MAX; i++) mem[i] = DW'(i);
        @(negedge clk);
        length = 5'd8; tb_len = 8; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset busy", busy, 1);
        chk("pre_reset rd_en", rd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset busy", busy, 0);
        chk("mid_reset done", done, 0);
        chk("mid_reset sorted", sorted, 0);
        chk("mid_reset rd_en", rd_en, 0);
        chk("mid_reset rd_addr", rd_addr, 0);
        chk("mid_reset inv_index", inv_index, 0);
`ifdef ARRAY_SORT_CHECK_COUNT_EN
        chk("mid_reset inv_count", inv_count, 0);
`endif
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset idle busy", busy, 0);
        chk("post_reset idle done", done, 0);
        mem[0] = 8'd5; mem[1] = 8'd1; mem[2] = 8'd4; mem[3] = 8'd0;
        do_test("after_reset", 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
